game_seq: RTL

GAME_SEQ -- requirements
Module: game_seq

---
 rtl/game_pkg.sv | 29 ++
 rtl/game_seq_btn_sync.sv | 32 +++
 rtl/game_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: state encodings, speed thresholds, flash periods and
// the score-to-speed mapping used by the game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_HIT     = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam int unsigned SCORE_MAX         = 99;
  localparam int unsigned SPEED_T1          = 25;
  localparam int unsigned SPEED_T2          = 50;
  localparam int unsigned SPEED_T3          = 75;
  localparam int unsigned FLASH_HIT_PERIOD  = 8;
  localparam int unsigned FLASH_OVER_PERIOD = 16;

  // Scores above SCORE_MAX are clamped before banding.
  function automatic logic [1:0] speed_of(input logic [6:0] score);
    logic [6:0] s;
    s = (score > 7'(SCORE_MAX)) ? 7'(SCORE_MAX) : score;
    if (s >= 7'(SPEED_T3))      return 2'd3;
    else if (s >= 7'(SPEED_T2)) return 2'd2;
    else if (s >= 7'(SPEED_T1)) return 2'd1;
    else                        return 2'd0;
  endfunction

endpackage

// File: rtl/game_seq_btn_sync.sv
// Two-flop synchronizer for a raw button plus a one-cycle rising-edge pulse
// derived from the synchronized level.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic sync,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/game_seq.sv
// Game sequencer: ATTRACT/PLAY/HIT/OVER flow with lives, frame-timed freeze
// and lockout, scroller control, speed level and sprite blink.
module game_seq
  import game_pkg::*;
#(
  parameter int unsigned HIT_FRAMES     = 60,
  parameter int unsigned LOCKOUT_FRAMES = 30,
  parameter int unsigned START_LIVES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_move,
  input  logic       collision,
  input  logic [6:0] score,
  output logic       scroll_en,
  output logic       scroll_rst,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [1:0] speed_lvl,
  output logic       flash
);

  localparam int unsigned CNT_MAX = (HIT_FRAMES > LOCKOUT_FRAMES) ? HIT_FRAMES : LOCKOUT_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  state_t           state_q, state_next;
  logic [1:0]       lives_q, lives_next;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       blink_q;
  logic [3:0]       blink_last;
  logic             flash_q;
  logic             scroll_en_q;
  logic             scroll_rst_q;
  logic             scroll_rst_set;
  logic [1:0]       speed_q;
  logic             move_d;
  logic             start_rise;
  logic             start_sync_unused;
  logic             move_sync;
  logic             move_rise_unused;
  logic             hit_done;
  logic             lockout_done;
  logic             state_change;

  btn_sync u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .sync  (start_sync_unused),
    .rise  (start_rise)
  );

  btn_sync u_move_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_move),
    .sync  (move_sync),
    .rise  (move_rise_unused)
  );

  // The tick that completes the freeze is counted here, so exit happens on it.
  assign hit_done     = (int'(cnt_q) + 1) >= int'(HIT_FRAMES);
  assign lockout_done = int'(cnt_q) >= int'(LOCKOUT_FRAMES);

  // NOTE: every variable written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next     = state_q;
    lives_next     = lives_q;
    scroll_rst_set = 1'b0;
    case (state_q)
      ST_ATTRACT: begin
        if (start_rise) begin
          state_next     = ST_PLAY;
          lives_next     = 2'(START_LIVES);
          scroll_rst_set = 1'b1;
        end
      end
      ST_PLAY: begin
        // Collision wins over a coincident start press.
        if (collision) begin
          state_next = ST_HIT;
          lives_next = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end
      end
      ST_HIT: begin
        if (frame_tick && hit_done)
          state_next = (lives_q == 2'd0) ? ST_OVER : ST_PLAY;
      end
      ST_OVER: begin
        if (start_rise && lockout_done)
          state_next = ST_ATTRACT;
      end
      default: state_next = ST_ATTRACT;
    endcase
  end

  assign state_change = (state_next != state_q);
  assign blink_last   = (state_q == ST_HIT) ? 4'(FLASH_HIT_PERIOD - 1)
                                            : 4'(FLASH_OVER_PERIOD - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ATTRACT;
      lives_q      <= 2'd0;
      scroll_rst_q <= 1'b1;
      scroll_en_q  <= 1'b0;
      move_d       <= 1'b0;
      speed_q      <= 2'd0;
    end else begin
      state_q      <= state_next;
      lives_q      <= lives_next;
      scroll_rst_q <= scroll_rst_set;
      move_d       <= move_sync;
      // Drops in the collision cycle because state_next already left PLAY.
      scroll_en_q  <= (state_q == ST_PLAY && state_next == ST_PLAY) ? move_d : 1'b0;
      speed_q      <= (state_next == ST_PLAY || state_next == ST_HIT) ? speed_of(score) : 2'd0;
    end
  end

  // Frame counter and blink divider restart on every state entry, so a tick
  // landing on a transition is never counted in the new state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 4'd0;
      flash_q <= 1'b0;
    end else if (state_change) begin
      cnt_q   <= '0;
      blink_q <= 4'd0;
      flash_q <= 1'b0;
    end else if (frame_tick) begin
      if (cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_HIT || state_q == ST_OVER) begin
        if (blink_q == blink_last) begin
          blink_q <= 4'd0;
          flash_q <= ~flash_q;
        end else begin
          blink_q <= blink_q + 4'd1;
        end
      end
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign scroll_en  = scroll_en_q;
  assign scroll_rst = scroll_rst_q;
  assign speed_lvl  = speed_q;
  assign flash      = flash_q;

endmodule
